fifo_write_packer: RTL and testbench
====================================

Name: fifo_write_packer

Overview:
Write-domain stage that sits directly upstream of async_fifo. It accepts a narrow byte stream over a valid/ready handshake and packs it into BITS-wide words, little-endian. It drives the FIFO write port (p_write_en/p_write_data) and honours p_write_full. s_last flushes a partial word padded with PAD. Runs entirely on write_clk; no CDC inside.

Parameters:
BITS, 32, output word width; must equal the async_fifo BITS.
IN_BITS, 8, input lane width; BITS/IN_BITS = RATIO must be an integer >= 2 (elaboration-time $fatal otherwise).
PAD, 0, IN_BITS-wide fill value for unfilled lanes on flush.

Ports:
write_clk  in  1  clock
write_rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input lane valid
s_ready  out  1  input lane ready
s_data  in  IN_BITS  input lane data
s_last  in  1  last lane of packet; forces word emission
p_write_en  out  1  FIFO write strobe, to async_fifo
p_write_data  out  BITS  FIFO write data, to async_fifo
p_write_full  in  1  FIFO full flag, from async_fifo
word_count  out  32  words accepted by FIFO since reset, wraps modulo 2^32
partial  out  1  accumulator holds >= 1 lane not yet emitted

Behaviour:
- State: accumulator (BITS), lane index (0..RATIO-1), output register out_data/out_valid, word_count.
- Reset (async assert, sync release on write_clk):
  - out_valid=0, p_write_en=0, p_write_data=0.
  - lane=0, accumulator all lanes = PAD, partial=0, word_count=0.
  - s_ready=1 while in reset deasserted state.
- p_write_en = out_valid & ~p_write_full (combinational). p_write_data = out_data. A write is accepted at the write_clk edge where p_write_en=1.
- s_ready = ~out_valid | ~p_write_full (combinational). It does not depend on s_valid or s_last.
- Lane accept (s_valid & s_ready):
  - s_data is written to lane[lane index]. Lane 0 = bits [IN_BITS-1:0].
  - If lane==RATIO-1 or s_last=1: out_data <= accumulator with the current lane inserted and all higher unfilled lanes = PAD. Set out_valid=1, lane=0, accumulator reset to PAD.
  - Otherwise: lane <= lane+1.
- Output register update:
  - New word loaded and p_write_en=1 in the same cycle: out_data is replaced and out_valid stays 1. This gives back-to-back, no bubble.
  - p_write_en=1 and no new word: out_valid <= 0.
  - p_write_full=1 with out_valid=1: out_data held stable, s_ready=0, nothing accepted.
- Latency: the completing lane is accepted at edge N. p_write_en rises after edge N (visible in cycle N+1) if not full. Sustained throughput is one lane per cycle.
- s_last on the RATIO-th lane emits exactly one word, never an extra all-PAD word.
- s_last with lane==0 and a valid byte emits a word with lanes 1..RATIO-1 = PAD.
- s_valid=0 never emits a word, including when partial=1. Flushing requires s_last.
- word_count increments by 1 on each accepted write (p_write_en=1 at edge).
- partial = (lane != 0).
- Reset mid-operation: any partial word and pending out_data are discarded, with no write after release.
- p_write_full going 1 in the same cycle out_valid rises: p_write_en stays 0 until full clears. The word is then written exactly once.
- X on s_data when s_valid=0 is ignored. p_write_data must never carry X while p_write_en=1.

Test Plan:
- Reset: hold write_rst_n=0 for 3 cycles, p_write_full=0 → p_write_en=0, p_write_data=0, s_ready=1, partial=0, word_count=0.
- Basic pack: lanes 0x11,0x22,0x33,0x44 on consecutive cycles, s_last=0 → one write, p_write_data=0x44332211, word_count=1, partial=0.
- Flush: 0xAA then 0xBB with s_last=1, PAD=0 → one write of 0x0000BBAA. A 4-lane packet with s_last on 0x44 → exactly one write.
- Backpressure: force p_write_full=1 with a word pending → s_ready=0 and p_write_data stable for 10 cycles with no write. Release → exactly one write, then s_ready=1.
- Streaming with async_fifo (SIZE=16): push 64 lanes 0x00..0x3F while reading → 16 words 0x03020100..0x3F3E3D3C in order, word_count=16, no loss while full toggles.
- Reset mid-word: 3 lanes accepted, then reset pulse → partial=0, no write. Next 4 lanes 0x01..0x04 → 0x04030201.

Source files
------------

// File: rtl/fifo_write_packer.sv
// Packs a narrow valid/ready lane stream into little-endian BITS-wide words
// and drives the async_fifo write port. Runs entirely on write_clk.
module fifo_write_packer #(
    parameter int                 BITS    = 32,
    parameter int                 IN_BITS = 8,
    parameter logic [IN_BITS-1:0] PAD     = '0
) (
    input  logic               write_clk,
    input  logic               write_rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [IN_BITS-1:0] s_data,
    input  logic               s_last,
    output logic               p_write_en,
    output logic [BITS-1:0]    p_write_data,
    input  logic               p_write_full,
    output logic [31:0]        word_count,
    output logic               partial
);

    localparam int RATIO  = BITS / IN_BITS;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (((BITS % IN_BITS) != 0) || (RATIO < 2)) begin : g_bad_ratio
        $fatal(1, "fifo_write_packer: BITS/IN_BITS must be an integer >= 2");
    end

    localparam logic [BITS-1:0] PAD_WORD = {RATIO{PAD}};

    logic [BITS-1:0]   acc;
    logic [BITS-1:0]   merged;
    logic [BITS-1:0]   out_data;
    logic              out_valid;
    logic [LANE_W-1:0] lane;
    logic              accept;
    logic              complete;

    assign p_write_en   = out_valid & ~p_write_full;
    assign p_write_data = out_data;
    assign s_ready      = ~out_valid | ~p_write_full;
    assign accept       = s_valid & s_ready;
    assign complete     = (lane == LANE_W'(RATIO - 1)) | s_last;
    assign partial      = (lane != '0);

    // Unfilled lanes of acc already hold PAD, so inserting the current
    // lane yields the padded word on an early flush.
    always_comb begin
        merged = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i)) begin
                merged[i*IN_BITS +: IN_BITS] = s_data;
            end
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            acc      <= PAD_WORD;
            lane     <= '0;
            out_data <= '0;
        end else if (accept) begin
            if (complete) begin
                out_data <= merged;
                acc      <= PAD_WORD;
                lane     <= '0;
            end else begin
                acc      <= merged;
                lane     <= lane + LANE_W'(1);
            end
        end
    end

    // A newly completed word takes priority so a write and a reload in the
    // same cycle keep out_valid high with no bubble.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            out_valid <= 1'b0;
        end else if (accept && complete) begin
            out_valid <= 1'b1;
        end else if (p_write_en) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            word_count <= '0;
        end else if (p_write_en) begin
            word_count <= word_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fifo_write_packer.sv
// Directed bench for fifo_write_packer: expected words are queued as lanes
// are driven and popped by a write-port monitor.
module tb_fifo_write_packer;

    logic        write_clk = 1'b0;
    logic        write_rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        p_write_en;
    logic [31:0] p_write_data;
    logic        p_write_full;
    logic [31:0] word_count;
    logic        partial;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    bit          stream_on = 1'b0;

    fifo_write_packer #(.BITS(32), .IN_BITS(8), .PAD(8'h00)) dut (
        .write_clk    (write_clk),
        .write_rst_n  (write_rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .p_write_en   (p_write_en),
        .p_write_data (p_write_data),
        .p_write_full (p_write_full),
        .word_count   (word_count),
        .partial      (partial)
    );

    always #5 write_clk = ~write_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so sampling at
    // the falling edge sees exactly what the next rising edge will commit.
    always @(negedge write_clk) begin
        if (p_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("[TB] FAIL unexpected_write: observed %h expected no write", p_write_data);
            end else begin
                check_output("write_data", p_write_data, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge write_clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic last);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge write_clk);
        while (!s_ready && waited < 200) begin
            waited++;
            @(negedge write_clk);
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $error("[TB] FAIL ready_timeout: observed s_ready=0 expected 1 within 200 cycles");
        end
        @(posedge write_clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 'x;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge write_clk);
            #1;
            w++;
        end
        check_output("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        write_rst_n  = 1'b0;
        s_valid      = 1'b0;
        s_data       = 'x;
        s_last       = 1'b0;
        p_write_full = 1'b0;

        // Reset state
        idle(3);
        check_output("rst_write_en", p_write_en, 0);
        check_output("rst_write_data", p_write_data, 0);
        check_output("rst_s_ready", s_ready, 1);
        check_output("rst_partial", partial, 0);
        check_output("rst_word_count", word_count, 0);
        write_rst_n = 1'b1;
        idle(2);

        // Basic four-lane pack
        exp_q.push_back(32'h44332211);
        apply_stimulus(8'h11, 1'b0);
        apply_stimulus(8'h22, 1'b0);
        apply_stimulus(8'h33, 1'b0);
        check_output("basic_partial_mid", partial, 1);
        apply_stimulus(8'h44, 1'b0);
        drain();
        check_output("basic_word_count", word_count, 1);
        check_output("basic_partial_end", partial, 0);

        // Two-lane flush
        exp_q.push_back(32'h0000BBAA);
        apply_stimulus(8'hAA, 1'b0);
        apply_stimulus(8'hBB, 1'b1);
        drain();
        idle(3);
        check_output("flush_word_count", word_count, 2);

        // s_last on the final lane must not add a PAD word
        exp_q.push_back(32'h44332211);
        apply_stimulus(8'h11, 1'b0);
        apply_stimulus(8'h22, 1'b0);
        apply_stimulus(8'h33, 1'b0);
        apply_stimulus(8'h44, 1'b1);
        drain();
        idle(4);
        check_output("last4_word_count", word_count, 3);

        // s_last on lane 0
        exp_q.push_back(32'h0000005A);
        apply_stimulus(8'h5A, 1'b1);
        drain();
        check_output("lane0_word_count", word_count, 4);

        // Idle with a partial word never emits
        exp_q.push_back(32'hDDCCBBAA);
        apply_stimulus(8'hAA, 1'b0);
        apply_stimulus(8'hBB, 1'b0);
        idle(5);
        check_output("idle_partial", partial, 1);
        check_output("idle_write_en", p_write_en, 0);
        check_output("idle_word_count", word_count, 4);
        apply_stimulus(8'hCC, 1'b0);
        apply_stimulus(8'hDD, 1'b0);
        drain();
        check_output("idle_done_count", word_count, 5);

        // Backpressure with a pending word
        p_write_full = 1'b1;
        exp_q.push_back(32'h87654321);
        apply_stimulus(8'h21, 1'b0);
        apply_stimulus(8'h43, 1'b0);
        apply_stimulus(8'h65, 1'b0);
        apply_stimulus(8'h87, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge write_clk);
            check_output("bp_s_ready", s_ready, 0);
            check_output("bp_write_en", p_write_en, 0);
            check_output("bp_data_stable", p_write_data, 32'h87654321);
        end
        @(posedge write_clk);
        #1;
        p_write_full = 1'b0;
        drain();
        check_output("bp_s_ready_after", s_ready, 1);
        check_output("bp_word_count", word_count, 6);

        // Streaming 64 lanes while the full flag toggles
        for (int w = 0; w < 16; w++) begin
            exp_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        stream_on = 1'b1;
        fork
            begin
                while (stream_on) begin
                    @(posedge write_clk);
                    #1;
                    p_write_full = ($urandom_range(0, 2) == 0);
                end
                p_write_full = 1'b0;
            end
        join_none
        for (int b = 0; b < 64; b++) begin
            apply_stimulus(8'(b), 1'b0);
        end
        stream_on = 1'b0;
        idle(2);
        drain();
        check_output("stream_word_count", word_count, 22);

        // Reset in the middle of a word discards it
        apply_stimulus(8'h10, 1'b0);
        apply_stimulus(8'h20, 1'b0);
        apply_stimulus(8'h30, 1'b0);
        check_output("midrst_partial_before", partial, 1);
        write_rst_n = 1'b0;
        idle(2);
        write_rst_n = 1'b1;
        idle(1);
        check_output("midrst_partial_after", partial, 0);
        check_output("midrst_word_count", word_count, 0);
        idle(5);
        check_output("midrst_no_write", p_write_en, 0);
        exp_q.push_back(32'h04030201);
        apply_stimulus(8'h01, 1'b0);
        apply_stimulus(8'h02, 1'b0);
        apply_stimulus(8'h03, 1'b0);
        apply_stimulus(8'h04, 1'b0);
        drain();
        check_output("midrst_final_count", word_count, 1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
